// File: rtl/traffic_light_ctrl_if.sv
// Handshake between the intersection controller and its phase Timer:
// the controller loads a duration, the Timer reports when it has elapsed.
interface traffic_light_ctrl_if;
  logic       startTimer;
  logic [3:0] parm_Value;
  logic       expired;

  modport master (
    output startTimer,
    output parm_Value,
    input  expired
  );

  modport slave (
    input  startTimer,
    input  parm_Value,
    output expired
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Main/side intersection controller FSM sitting directly upstream of a phase Timer.
// Optional pedestrian walk phase is compiled in when WALK_REQ_EN is defined.
module traffic_light_ctrl #(
  parameter logic [3:0] T_MAIN = 4'd8,
  parameter logic [3:0] T_SIDE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_RED  = 4'd1,
  parameter logic [3:0] T_WALK = 4'd5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sensor,
  input  logic                        walk_req,
  traffic_light_ctrl_if.master        tmr,
  output logic [2:0]                  main_light,
  output logic [2:0]                  side_light,
  output logic                        walk
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    MAIN_G      = 3'd1,
    MAIN_Y      = 3'd2,
    RED_TO_SIDE = 3'd3,
    SIDE_G      = 3'd4,
    SIDE_Y      = 3'd5,
    RED_TO_MAIN = 3'd6,
    WALK        = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] parm_q, parm_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       car_wait_q, car_wait_d;
  logic       ext_used_q, ext_used_d;
  logic       walk_pend_q, walk_pend_d;
  logic       exp_ok;
  logic       enter_side;
  logic       enter_walk;

  // An expiry seen while a load is in flight belongs to the previous phase
  assign exp_ok = tmr.expired && !start_q && (state_q != INIT);

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    parm_d     = parm_q;
    ext_used_d = ext_used_q;

    case (state_q)
      INIT: begin
        state_d = MAIN_G;
        start_d = 1'b1;
        parm_d  = T_MAIN;
      end
      MAIN_G: begin
        if (exp_ok) begin
          start_d = 1'b1;
          if (car_wait_q || walk_pend_q) begin
            state_d = MAIN_Y;
            parm_d  = T_YEL;
          end else begin
            parm_d  = T_MAIN;
          end
        end
      end
      MAIN_Y: begin
        if (exp_ok) begin
          state_d = RED_TO_SIDE;
          start_d = 1'b1;
          parm_d  = T_RED;
        end
      end
      RED_TO_SIDE: begin
        if (exp_ok) begin
          start_d = 1'b1;
          if (walk_pend_q) begin
            state_d = WALK;
            parm_d  = T_WALK;
          end else begin
            state_d = SIDE_G;
            parm_d  = T_SIDE;
          end
        end
      end
      SIDE_G: begin
        if (exp_ok) begin
          start_d = 1'b1;
          if (sensor && !ext_used_q) begin
            parm_d     = T_EXT;
            ext_used_d = 1'b1;
          end else begin
            state_d = SIDE_Y;
            parm_d  = T_YEL;
          end
        end
      end
      SIDE_Y: begin
        if (exp_ok) begin
          state_d = RED_TO_MAIN;
          start_d = 1'b1;
          parm_d  = T_RED;
        end
      end
      RED_TO_MAIN: begin
        if (exp_ok) begin
          state_d = MAIN_G;
          start_d = 1'b1;
          parm_d  = T_MAIN;
        end
      end
      WALK: begin
        if (exp_ok) begin
          start_d = 1'b1;
          if (car_wait_q) begin
            state_d = SIDE_G;
            parm_d  = T_SIDE;
          end else begin
            state_d = RED_TO_MAIN;
            parm_d  = T_RED;
          end
        end
      end
      default: begin
        state_d = INIT;
        parm_d  = 4'd0;
      end
    endcase

    enter_side = (state_d == SIDE_G) && (state_q != SIDE_G);
    enter_walk = (state_d == WALK) && (state_q != WALK);

    if (enter_side) begin
      ext_used_d = 1'b0;
    end

    // Clearing takes priority over a coincident sensor or button sample
    car_wait_d = enter_side ? 1'b0 : (car_wait_q | sensor);
`ifdef WALK_REQ_EN
    walk_pend_d = enter_walk ? 1'b0 : (walk_pend_q | walk_req);
`else
    walk_pend_d = 1'b0;
`endif

    main_d = LAMP_R;
    side_d = LAMP_R;
    walk_d = 1'b0;
    case (state_d)
      MAIN_G:  main_d = LAMP_G;
      MAIN_Y:  main_d = LAMP_Y;
      SIDE_G:  side_d = LAMP_G;
      SIDE_Y:  side_d = LAMP_Y;
      WALK:    walk_d = 1'b1;
      default: begin
        main_d = LAMP_R;
        side_d = LAMP_R;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      start_q    <= 1'b0;
      parm_q     <= 4'd0;
      main_q     <= LAMP_R;
      side_q     <= LAMP_R;
      walk_q     <= 1'b0;
      car_wait_q <= 1'b0;
      ext_used_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      parm_q     <= parm_d;
      main_q     <= main_d;
      side_q     <= side_d;
      walk_q     <= walk_d;
      car_wait_q <= car_wait_d;
      ext_used_q <= ext_used_d;
    end
  end

`ifdef WALK_REQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_pend_q <= 1'b0;
    end else begin
      walk_pend_q <= walk_pend_d;
    end
  end
`else
  // Without the walk feature the latch is a constant and the button is dropped
  logic unused_walk_inputs;
  assign walk_pend_q        = 1'b0;
  assign unused_walk_inputs = walk_req ^ (|T_WALK) ^ walk_pend_d ^ enter_walk;
`endif

  assign tmr.startTimer = start_q;
  assign tmr.parm_Value = parm_q;
  assign main_light     = main_q;
  assign side_light     = side_q;
  assign walk           = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: stimulus queues the expected phase,
// a monitor pops and compares it on every startTimer pulse.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct packed {
    logic [3:0] parm;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor;
  logic       walk_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  logic [3:0] last_parm = 4'd0;

  traffic_light_ctrl_if tmr ();

  traffic_light_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .walk_req   (walk_req),
    .tmr        (tmr.master),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one Timer expiry; the expected next phase is queued first
  task automatic apply_stimulus(input logic [3:0] parm, input logic [2:0] m,
                                input logic [2:0] s, input logic w, input int hold);
    exp_t e;
    repeat (2) @(negedge clk);
    e.parm   = parm;
    e.main_l = m;
    e.side_l = s;
    e.walk_l = w;
    exp_q.push_back(e);
    tmr.expired = 1'b1;
    repeat (hold) @(negedge clk);
    tmr.expired = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_main"},  {1'b0, main_light}, 4'b0100);
    check_output({tag, "_side"},  {1'b0, side_light}, 4'b0100);
    check_output({tag, "_walk"},  {3'b0, walk}, 4'd0);
    check_output({tag, "_start"}, {3'b0, tmr.startTimer}, 4'd0);
    check_output({tag, "_parm"},  tmr.parm_Value, 4'd0);
  endtask

  // Monitor: every startTimer pulse must match the oldest queued phase
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_parm = 4'd0;
      end else begin
        tests_run++;
        if (main_light == G && side_light == G) begin
          tests_failed++;
          $display("[TB] FAIL both_green: main %b side %b at %0t", main_light, side_light, $time);
        end
        if (tmr.startTimer) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_start: parm %0d, expected no pulse at %0t",
                     tmr.parm_Value, $time);
          end else begin
            e = exp_q.pop_front();
            check_output("parm_Value", tmr.parm_Value, e.parm);
            check_output("main_light", {1'b0, main_light}, {1'b0, e.main_l});
            check_output("side_light", {1'b0, side_light}, {1'b0, e.side_l});
            check_output("walk",       {3'b0, walk}, {3'b0, e.walk_l});
          end
          last_parm = tmr.parm_Value;
        end else begin
          check_output("parm_hold", tmr.parm_Value, last_parm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    reset       = 1'b0;
    sensor      = 1'b0;
    walk_req    = 1'b0;
    tmr.expired = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    e.parm = 4'd8; e.main_l = G; e.side_l = R; e.walk_l = 1'b0;
    exp_q.push_back(e);
    reset = 1'b1;

    // No car: main green simply restarts
    repeat (3) apply_stimulus(4'd8, G, R, 1'b0, 1);

    // Held expiry: the second cycle falls on the load and is ignored
    apply_stimulus(4'd8, G, R, 1'b0, 2);

    // Single-cycle sensor pulse triggers a full side cycle
    @(negedge clk) sensor = 1'b1;
    @(negedge clk) sensor = 1'b0;
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd6, R, G, 1'b0, 1);
    apply_stimulus(4'd2, R, Y, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd8, G, R, 1'b0, 1);

    // Sensor held: one extension only
    @(negedge clk) sensor = 1'b1;
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd6, R, G, 1'b0, 1);
    apply_stimulus(4'd3, R, G, 1'b0, 1);
    apply_stimulus(4'd2, R, Y, 1'b0, 1);
    sensor = 1'b0;
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd8, G, R, 1'b0, 1);

    // Car latched during SIDE_Y forces another side cycle; extension re-armed
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd6, R, G, 1'b0, 1);
    @(negedge clk) sensor = 1'b1;
    apply_stimulus(4'd3, R, G, 1'b0, 1);
    sensor = 1'b0;
    apply_stimulus(4'd2, R, Y, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd8, G, R, 1'b0, 1);
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd6, R, G, 1'b0, 1);
    apply_stimulus(4'd2, R, Y, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd8, G, R, 1'b0, 1);

    @(negedge clk) walk_req = 1'b1;
    @(negedge clk) walk_req = 1'b0;
`ifdef WALK_REQ_EN
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd5, R, R, 1'b1, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd8, G, R, 1'b0, 1);
`else
    apply_stimulus(4'd8, G, R, 1'b0, 1);
`endif

    // Reset during an extension load, with car_wait and ext_used set
    @(negedge clk) sensor = 1'b1;
    @(negedge clk) sensor = 1'b0;
    apply_stimulus(4'd2, Y, R, 1'b0, 1);
    apply_stimulus(4'd1, R, R, 1'b0, 1);
    apply_stimulus(4'd6, R, G, 1'b0, 1);
    sensor = 1'b1;
    apply_stimulus(4'd3, R, G, 1'b0, 1);
    #1 reset = 1'b0;
    sensor = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    check_reset_values("held_reset");
    e.parm = 4'd8; e.main_l = G; e.side_l = R; e.walk_l = 1'b0;
    exp_q.push_back(e);
    reset = 1'b1;
    apply_stimulus(4'd8, G, R, 1'b0, 1);

    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL pending_phases: %0d phases never started, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

- Controller FSM for a main/side intersection; sits directly upstream of `Timer`.
- Each light phase is started by loading a 4-bit duration into `Timer` via `parm_Value`/`startTimer`; the phase ends on `Timer`'s `expired`.
- A latched side-street car sensor controls phase changes; side green can be extended once.
- A pedestrian walk phase is optional, selected by a compile-time macro.

## Interface
- `T_MAIN`, 4'd8, main green duration (timer units)
- `T_SIDE`, 4'd6, side green duration
- `T_EXT`, 4'd3, one-shot side green extension
- `T_YEL`, 4'd2, yellow duration, both directions
- `T_RED`, 4'd1, all-red clearance duration
- `T_WALK`, 4'd5, walk phase duration (used only with walk compiled in)
- `clk` in 1: single system clock, rising edge
- `reset` in 1: asynchronous, active-low
- `sensor` in 1: side-street car present, level
- `walk_req` in 1: pedestrian button, level/pulse
- `expired` in 1: from `Timer`, current duration elapsed
- `startTimer` out 1: one-cycle pulse loading `parm_Value` into `Timer`
- `parm_Value` out 4: duration of the phase just entered
- `main_light` out 3: one-hot {R,Y,G} for the main street
- `side_light` out 3: one-hot {R,Y,G} for the side street
- `walk` out 1: walk lamp

## Operation
**State sequence**
- States: INIT, MAIN_G, MAIN_Y, RED_TO_SIDE, SIDE_G, SIDE_Y, RED_TO_MAIN, WALK.
- INIT → MAIN_G unconditionally on the first clock after reset release.
- MAIN_G expired:
  - `car_wait` (or `walk_pend`, when walk is compiled in) set → MAIN_Y.
  - Otherwise re-enter MAIN_G; a fresh `startTimer` with `T_MAIN` is issued.
- MAIN_Y expired → RED_TO_SIDE.
- RED_TO_SIDE expired → WALK if `walk_pend`, else SIDE_G.
- SIDE_G expired:
  - `sensor` high live and `ext_used`=0 → stay in SIDE_G, restart with `T_EXT`, set `ext_used`.
  - Otherwise → SIDE_Y.
- SIDE_Y expired → RED_TO_MAIN.
- RED_TO_MAIN expired → MAIN_G.
- WALK expired → SIDE_G if `car_wait`, else RED_TO_MAIN.

**Lamps**
- MAIN_G: main G, side R. MAIN_Y: main Y, side R. SIDE_G: side G, main R. SIDE_Y: side Y, main R.
- INIT, both RED_TO_* states and WALK: both R.
- `walk`=1 only in WALK.
- Green in both directions is never legal.

**Latches**
- `car_wait` is set by `sensor`=1 on any clock and cleared on entry to SIDE_G. If set and clear coincide, clear wins.
- `ext_used` is cleared on every entry to SIDE_G from another state.
- `walk_pend` is set by `walk_req` and cleared on entry to WALK. If set and clear coincide, clear wins.

**Phase durations**
- Every phase entry, including re-entry, emits one `startTimer` pulse. `parm_Value` carries the phase duration (`T_MAIN`, `T_YEL`, `T_RED`, `T_SIDE`, `T_EXT`, `T_WALK`).
- `parm_Value` holds its value until the next pulse.
- Duration parameters must be 1..15; a value of 0 is illegal and its behaviour is undefined.

## Timing
- All outputs are registered.
- Reset values: INIT state, `main_light`=`side_light`=3'b100, `walk`=0, `startTimer`=0, `parm_Value`=0. All latches are 0.
- Asserting `reset` mid-phase forces the reset values immediately, without waiting for a clock.
- Phase change latency:
  - The state change, lamp update, `startTimer`=1 and new `parm_Value` appear at the same edge that samples `expired`=1.
  - Zero extra cycles are added.
- `expired` is ignored in INIT and in any cycle where `startTimer` is 1; this masks the stale expiry from `Timer`.
- `sensor`/`walk_req` are sampled only at rising edges. A pulse shorter than one clock period may be missed.

## Configuration
- `WALK_REQ_EN` defined:
  - WALK state, `walk_pend` latch and walk decisions in MAIN_G and RED_TO_SIDE are compiled in.
- `WALK_REQ_EN` undefined:
  - WALK state and `walk_pend` are removed; `walk_req` is ignored.
  - `walk` is tied to 0; RED_TO_SIDE always goes to SIDE_G.

## Test plan
- Reset low 2 cycles, then release:
  - During reset: all outputs at reset values.
  - Next edge: MAIN_G, `startTimer` pulse, `parm_Value`=8.
- No sensor, `expired` pulsed 3 times → MAIN_G held; three `startTimer` pulses, each with `parm_Value`=8.
- `sensor` high 1 cycle during MAIN_G, then `expired` per phase → sequence with `parm_Value` values:
  - MAIN_Y (2)
  - RED_TO_SIDE (1)
  - SIDE_G (6)
  - SIDE_Y (2)
  - RED_TO_MAIN (1)
  - MAIN_G (8)
- `sensor` held high through SIDE_G:
  - First expiry: SIDE_G restarts with `parm_Value`=3.
  - Second expiry: SIDE_Y; never a second extension.
- `WALK_REQ_EN`, `walk_req` pulse in MAIN_G, no car:
  - Path: MAIN_Y → RED_TO_SIDE → WALK (`walk`=1, `parm_Value`=5) → RED_TO_MAIN → MAIN_G.
- `reset` asserted mid-SIDE_G → `side_light`=3'b100 and `startTimer`=0 without waiting for a clock; all latches cleared.
